seg7_bcd_feed: RTL
==================

# seg7_bcd_feed

Two-digit decimal up/down counter that produces the 14-bit `both7seg` pattern word consumed by the two-digit seven-segment multiplexer. It sits directly upstream of the multiplexer: it takes raw push-button levels, synchronises them and edge-detects them, and maintains a BCD count. Each digit is encoded to active-high segment patterns, and the result is presented as a registered `{tens, ones}` pattern pair.

## Interface
- `MAX_COUNT`, default 99: upper count limit, legal range 1..99; wrap point in both directions.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inc`  in  1  asynchronous button level; each rising edge is one increment request.
- `dec`  in  1  asynchronous button level; each rising edge is one decrement request.
- `clr`  in  1  synchronous clear level, sampled directly with no synchroniser.
- `both7seg`  out  14  bits [13:7] = tens pattern, bits [6:0] = ones pattern; registered.
- `bcd`  out  8  `{tens[3:0], ones[3:0]}` current count; registered.
- `ovf`  out  1  one-cycle pulse on up-wrap from `MAX_COUNT` to 0.
- `unf`  out  1  one-cycle pulse on down-wrap from 0 to `MAX_COUNT`.
- `upd`  out  1  one-cycle pulse, coincident with the cycle in which `both7seg` takes a new value.

## Operation
- **Input synchronisation:** `inc` and `dec` each pass through a 2-flop synchroniser, then a previous-value flop.
  - Edge detect: `edge = sync2 & !prev`.
- **Count:** held as two BCD digits, `ones` 0..9 and `tens` 0..9. Binary arithmetic on the combined value is not allowed.
  - Up: `ones==9` → `ones=0`, `tens+1`.
  - Down: `ones==0` → `ones=9`, `tens-1`.
- **Wrap:**
  - Up from `{MAX_COUNT/10, MAX_COUNT%10}` → 00, and `ovf`=1.
  - Down from 00 → `MAX_COUNT`, and `unf`=1.
- **Priority:**
  - `clr` beats everything, including pending edges; no `ovf`/`unf` is generated.
  - An inc edge and a dec edge in the same cycle cancel: no change, no pulse.
- **Segment encoding:** bit0=a … bit6=g, active-high.
  - Patterns for 0..9: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F (hex).
- **Output register:** `both7seg` is registered from the count. `upd` is asserted in the cycle the register loads a value different from its previous contents.
- **Reset values:**
  - count = 00, all synchroniser and prev flops = 0.
  - `bcd`=8'h00, `ovf`=`unf`=`upd`=0.
  - `both7seg`=14'h1FBF, or 14'h003F with `SEG7_LZB_EN`.
- **Reset mid-operation:** any in-flight edge is discarded. A button still held high across reset release produces no edge, because prev was cleared and sync re-fills from 0. An edge fires only once `sync2` becomes 1 after release; this is intended, and the bench must expect exactly one count in that case.

## Timing
- `inc` high sampled at edge E1 → `sync1`. E2 → `sync2`, and `edge` is valid. E3 → count, `bcd`, `ovf`/`unf` update. E4 → `both7seg` updates with `upd`=1.
- Latency from first sampled-high edge to count change: 3 clocks. To `both7seg`: 4 clocks.
- `clr` sampled at E → count 00 at E. `both7seg` reflects it at E+1.
- A held button produces one request only; re-arming requires `inc` low for at least 1 sampled cycle.
- Maximum request rate: one per 2 clocks per input (high cycle plus low cycle).

## Configuration
- `SEG7_LZB_EN` defined: leading-zero blanking. When `tens==0`, bits [13:7] = 7'h00. Ones is never blanked.
- `SEG7_LZB_EN` undefined: the tens pattern is always driven, so 0 shows 3F.

## Structure
- Package `seg7_pkg` holds:
  - the ten digit-pattern constants and `SEG_BLANK`=7'h00;
  - a `bcd_digit_t` 4-bit typedef;
  - the bit-index constants for segments a..g.
- Sub-module `seg7_decode` is combinational: 4-bit digit in, 7-bit pattern out. Codes 10..15 decode to `SEG_BLANK`. It is instantiated twice.
- The top-level `seg7_bcd_feed` contains the synchronisers, edge detect, BCD counter, wrap/pulse logic and output registers.

## Test plan
- **Reset:** assert `rst` 2 cycles → `both7seg`=14'h1FBF (LZB: 14'h003F), `bcd`=00, all pulses 0.
- **Single increment:** one `inc` pulse 4 cycles wide from 00 → exactly one increment. `bcd`=01 at E3, `both7seg`={3F,06} at E4, `upd` pulse at E4.
- **Decade carry then up-wrap:** counting up from 09 → 10, `both7seg`={06,3F}. With `MAX_COUNT`=99, from 99 `inc` → 00, `ovf` high 1 cycle.
- **Down-wrap and custom limit:** `MAX_COUNT`=59, from 00 `dec` → 59 (`both7seg`={6D,6F}), `unf` high 1 cycle.
- **Simultaneous events:** `inc` and `dec` rising in the same cycle → no change and no pulses. `clr` with a pending inc edge at 42 → 00, no `ovf`.
- **Mid-operation reset:** reset asserted while `inc` is held, then released with `inc` still high → count stays 00 until `sync2` fills, then +1 once. Under `SEG7_LZB_EN`, value 05 → `both7seg`={00,6D}.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: BCD digit type, segment bit indices and active-high digit patterns
package seg7_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD digit to seven-segment pattern; codes 10..15 blank
module seg7_decode
  import seg7_pkg::*;
(
  input  bcd_digit_t digit,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/seg7_bcd_feed.sv
// seg7_bcd_feed: button-driven two-digit BCD up/down counter feeding a registered segment word.
// Define SEG7_LZB_EN to blank the tens digit when it is zero.
module seg7_bcd_feed
  import seg7_pkg::*;
#(
  parameter int MAX_COUNT = 99
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  output logic [13:0] both7seg,
  output logic [7:0]  bcd,
  output logic        ovf,
  output logic        unf,
  output logic        upd
);
  localparam bcd_digit_t MAX_T = bcd_digit_t'(MAX_COUNT / 10);
  localparam bcd_digit_t MAX_O = bcd_digit_t'(MAX_COUNT % 10);
`ifdef SEG7_LZB_EN
  localparam logic [13:0] SEG_RST = {SEG_BLANK, SEG_0};
`else
  localparam logic [13:0] SEG_RST = {SEG_0, SEG_0};
`endif
  logic [1:0] inc_s, dec_s;
  logic inc_p, dec_p, inc_e, dec_e, up, dn, at_max, at_zero;
  bcd_digit_t ones, tens, ones_n, tens_n;
  logic [6:0] seg_t, seg_o, seg_tb;
  logic [13:0] seg_n;
  assign inc_e = inc_s[1] & ~inc_p;
  assign dec_e = dec_s[1] & ~dec_p;
  assign up = inc_e & ~dec_e & ~clr;
  assign dn = dec_e & ~inc_e & ~clr;
  assign at_max = (tens == MAX_T) && (ones == MAX_O);
  assign at_zero = (tens == 4'd0) && (ones == 4'd0);
  always_comb begin
    ones_n = (clr || (up && at_max)) ? 4'd0 :
             up ? ((ones == 4'd9) ? 4'd0 : ones + 4'd1) :
             dn ? (at_zero ? MAX_O : (ones == 4'd0) ? 4'd9 : ones - 4'd1) : ones;
    tens_n = (clr || (up && at_max)) ? 4'd0 :
             up ? ((ones == 4'd9) ? tens + 4'd1 : tens) :
             dn ? (at_zero ? MAX_T : (ones == 4'd0) ? tens - 4'd1 : tens) : tens;
  end
  seg7_decode u_dec_t (.digit(tens), .seg(seg_t));
  seg7_decode u_dec_o (.digit(ones), .seg(seg_o));
`ifdef SEG7_LZB_EN
  assign seg_tb = (tens == 4'd0) ? SEG_BLANK : seg_t;
`else
  assign seg_tb = seg_t;
`endif
  assign seg_n = {seg_tb, seg_o};
  assign bcd = {tens, ones};
  always_ff @(posedge clk) begin
    if (rst) begin
      inc_s    <= '0;
      dec_s    <= '0;
      inc_p    <= 1'b0;
      dec_p    <= 1'b0;
      ones     <= '0;
      tens     <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
      both7seg <= SEG_RST;
      upd      <= 1'b0;
    end else begin
      inc_s    <= {inc_s[0], inc};
      dec_s    <= {dec_s[0], dec};
      inc_p    <= inc_s[1];
      dec_p    <= dec_s[1];
      ones     <= ones_n;
      tens     <= tens_n;
      ovf      <= up & at_max;
      unf      <= dn & at_zero;
      both7seg <= seg_n;
      upd      <= seg_n != both7seg;
    end
  end
endmodule
